// File: rtl/memctl_seq.sv
// ----------------------------------------------------------------------------
// memctl_seq - memory-cycle sequencer
//
// This block sits between the processor's memory-request logic and the
// external memory bus. It runs one bus cycle per accepted request. Read data
// is passed to the memory data register through mds/loadmd.
//
// Parameters:
//   TIMEOUT     bus cycles to wait for mem_ack before aborting (1..255)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   memrq       one-cycle request pulse; wrcyc selects write (1) or read (0)
//   vma, md     address and write data, sampled together with memrq
//   nxm_clr     clears the sticky nxm/ovr flags
//   mem_req, mem_we, mem_addr, mem_wdata   bus request side (held in REQ)
//   mem_ack, mem_rdata                     bus response side
//   mds, loadmd read word and its one-cycle load strobe
//   memstall    processor hold while a cycle is outstanding
//   nxm         sticky bus-timeout flag
//   ovr         sticky request-while-busy flag
// ----------------------------------------------------------------------------
module memctl_seq #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memrq,
    input  logic        wrcyc,
    input  logic [21:0] vma,
    input  logic [31:0] md,
    input  logic        nxm_clr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [21:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mds,
    output logic        loadmd,
    output logic        memstall,
    output logic        nxm,
    output logic        ovr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  cnt_r;
    logic        we_r;
    logic [21:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] mds_r;
    logic        nxm_r;
    logic        ovr_r;

    logic        accept_s;
    logic        expired_s;
    logic        timeout_s;
    logic        rd_load_s;
    logic        ovr_set_s;
    logic [31:0] rd_word_s;

    // Next-state decode and per-cycle event flags.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        expired_s = (cnt_r == TIMEOUT_C);
        timeout_s = 1'b0;
        rd_load_s = 1'b0;
        ovr_set_s = 1'b0;
        rd_word_s = 32'hFFFF_FFFF;
        case (state_r)
            ST_IDLE: begin
                if (memrq) begin
                    accept_s = 1'b1;
                    state_s  = ST_REQ;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_REQ: begin
                ovr_set_s = memrq;
                // An ack in the final wait cycle wins over the timeout.
                if (mem_ack) begin
                    rd_word_s = mem_rdata;
                    rd_load_s = ~we_r;
                    state_s   = we_r ? ST_IDLE : ST_DONE;
                end else if (expired_s) begin
                    timeout_s = 1'b1;
                    rd_load_s = ~we_r;
                    state_s   = we_r ? ST_IDLE : ST_DONE;
                end else begin
                    state_s   = ST_REQ;
                end
            end
            ST_DONE: begin
                ovr_set_s = memrq;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Wait-cycle counter: cleared on accept, counts unacknowledged REQ cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= 8'd0;
        end else if (accept_s) begin
            cnt_r <= 8'd0;
        end else if ((state_r == ST_REQ) && !mem_ack && !expired_s) begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    // Bus-cycle parameters, captured only when a request is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_r    <= 1'b0;
            addr_r  <= 22'd0;
            wdata_r <= 32'd0;
        end else if (accept_s) begin
            we_r    <= wrcyc;
            addr_r  <= vma;
            wdata_r <= md;
        end
    end

    // Read word: bus data on ack, all-ones on a read timeout; writes leave it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mds_r <= 32'd0;
        end else if (rd_load_s) begin
            mds_r <= rd_word_s;
        end
    end

    // Sticky error flags; a set event in the same cycle beats nxm_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nxm_r <= 1'b0;
            ovr_r <= 1'b0;
        end else begin
            if (timeout_s) begin
                nxm_r <= 1'b1;
            end else if (nxm_clr) begin
                nxm_r <= 1'b0;
            end
            if (ovr_set_s) begin
                ovr_r <= 1'b1;
            end else if (nxm_clr) begin
                ovr_r <= 1'b0;
            end
        end
    end

    // Strobes are decoded from the state register only, so a reset drops
    // mem_req at once and no loadmd can follow an abandoned cycle.
    assign mem_req   = (state_r == ST_REQ);
    assign loadmd    = (state_r == ST_DONE);
    assign memstall  = (state_r != ST_IDLE);
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mds       = mds_r;
    assign nxm       = nxm_r;
    assign ovr       = ovr_r;

endmodule

// File: tb/tb_memctl_seq.sv
// ----------------------------------------------------------------------------
// tb_memctl_seq - directed self-checking bench for memctl_seq
//
// Two instances share every input except memrq: dut uses the default
// TIMEOUT, dut_t4 uses TIMEOUT=4 for the timeout scenario.
// ----------------------------------------------------------------------------
module tb_memctl_seq;

    logic        clk;
    logic        reset;
    logic        memrq_a;
    logic        memrq_b;
    logic        wrcyc;
    logic [21:0] vma;
    logic [31:0] md;
    logic        nxm_clr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        mem_req_a, mem_we_a, loadmd_a, memstall_a, nxm_a, ovr_a;
    logic [21:0] mem_addr_a;
    logic [31:0] mem_wdata_a, mds_a;
    logic        mem_req_b, mem_we_b, loadmd_b, memstall_b, nxm_b, ovr_b;
    logic [21:0] mem_addr_b;
    logic [31:0] mem_wdata_b, mds_b;

    int tests_run    = 0;
    int tests_failed = 0;
    int req_cycles;

    memctl_seq dut (
        .clk(clk), .reset(reset), .memrq(memrq_a), .wrcyc(wrcyc), .vma(vma),
        .md(md), .nxm_clr(nxm_clr), .mem_req(mem_req_a), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mds(mds_a), .loadmd(loadmd_a),
        .memstall(memstall_a), .nxm(nxm_a), .ovr(ovr_a)
    );

    memctl_seq #(.TIMEOUT(4)) dut_t4 (
        .clk(clk), .reset(reset), .memrq(memrq_b), .wrcyc(wrcyc), .vma(vma),
        .md(md), .nxm_clr(nxm_clr), .mem_req(mem_req_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mds(mds_b), .loadmd(loadmd_b),
        .memstall(memstall_b), .nxm(nxm_b), .ovr(ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        memrq_a   = 1'b0;
        memrq_b   = 1'b0;
        wrcyc     = 1'b0;
        vma       = 22'd0;
        md        = 32'd0;
        nxm_clr   = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        step();
        step();
        check_val("rst_mem_req",  {31'd0, mem_req_a}, 32'd0);
        check_val("rst_memstall", {31'd0, memstall_a}, 32'd0);
        check_val("rst_mds",      mds_a, 32'd0);
        check_val("rst_flags",    {28'd0, loadmd_a, nxm_a, ovr_a, mem_we_a}, 32'd0);
        reset = 1'b1;
        step();

        // Read, ack in the first REQ cycle.
        memrq_a = 1'b1; wrcyc = 1'b0; vma = 22'h012345;
        step();
        memrq_a = 1'b0; vma = 22'h000000;
        check_val("rd_req",      {31'd0, mem_req_a}, 32'd1);
        check_val("rd_stall1",   {31'd0, memstall_a}, 32'd1);
        check_val("rd_addr",     {10'd0, mem_addr_a}, 32'h0001_2345);
        check_val("rd_we",       {31'd0, mem_we_a}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check_val("rd_loadmd",   {31'd0, loadmd_a}, 32'd1);
        check_val("rd_mds",      mds_a, 32'hDEADBEEF);
        check_val("rd_req_drop", {31'd0, mem_req_a}, 32'd0);
        check_val("rd_stall2",   {31'd0, memstall_a}, 32'd1);
        step();
        check_val("rd_idle",     {30'd0, memstall_a, loadmd_a}, 32'd0);

        // Write, ack after 5 wait cycles.
        memrq_a = 1'b1; wrcyc = 1'b1; vma = 22'h00ABCD; md = 32'h0000_CAFE;
        step();
        memrq_a = 1'b0; md = 32'h0;
        for (int i = 0; i < 6; i++) begin
            check_val("wr_req",   {31'd0, mem_req_a}, 32'd1);
            check_val("wr_we",    {31'd0, mem_we_a}, 32'd1);
            check_val("wr_wdata", mem_wdata_a, 32'h0000_CAFE);
            check_val("wr_noload", {31'd0, loadmd_a}, 32'd0);
            if (i == 5) mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        check_val("wr_done",     {30'd0, mem_req_a, memstall_a}, 32'd0);
        check_val("wr_noload2",  {31'd0, loadmd_a}, 32'd0);
        check_val("wr_mds_keep", mds_a, 32'hDEADBEEF);
        step();

        // Read timeout on the TIMEOUT=4 instance.
        wrcyc = 1'b0; vma = 22'h3F0000;
        memrq_b = 1'b1;
        step();
        memrq_b = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 20 && mem_req_b; i++) begin
            req_cycles++;
            check_val("to_noload", {31'd0, loadmd_b}, 32'd0);
            step();
        end
        check_val("to_req_len", req_cycles, 32'd5);
        check_val("to_nxm",     {31'd0, nxm_b}, 32'd1);
        check_val("to_loadmd",  {31'd0, loadmd_b}, 32'd1);
        check_val("to_mds",     mds_b, 32'hFFFF_FFFF);
        step();
        check_val("to_one_load", {31'd0, loadmd_b}, 32'd0);
        nxm_clr = 1'b1;
        step();
        nxm_clr = 1'b0;
        check_val("to_nxm_clr", {31'd0, nxm_b}, 32'd0);

        // Overlap: second memrq during REQ, sent together with nxm_clr.
        wrcyc = 1'b0; vma = 22'h001111;
        memrq_a = 1'b1;
        step();
        vma = 22'h002222; nxm_clr = 1'b1;
        step();
        memrq_a = 1'b0; nxm_clr = 1'b0;
        check_val("ov_ovr",  {31'd0, ovr_a}, 32'd1);
        check_val("ov_addr", {10'd0, mem_addr_a}, 32'h0000_1111);
        check_val("ov_req",  {31'd0, mem_req_a}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        check_val("ov_mds",  mds_a, 32'h1234_5678);
        check_val("ov_load", {31'd0, loadmd_a}, 32'd1);
        step();
        check_val("ov_no_req2", {31'd0, mem_req_a}, 32'd0);
        step();
        check_val("ov_no_req3", {30'd0, mem_req_a, memstall_a}, 32'd0);
        nxm_clr = 1'b1;
        step();
        nxm_clr = 1'b0;
        check_val("ov_clr", {31'd0, ovr_a}, 32'd0);

        // Back-to-back read then write at minimum spacing.
        wrcyc = 1'b0; vma = 22'h000777;
        memrq_a = 1'b1;
        step();
        memrq_a = 1'b0;
        check_val("bb_rd_addr", {10'd0, mem_addr_a}, 32'h0000_0777);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 1'b0;
        check_val("bb_rd_load", {31'd0, loadmd_a}, 32'd1);
        check_val("bb_rd_mds",  mds_a, 32'h0BAD_F00D);
        step();
        wrcyc = 1'b1; vma = 22'h3FFFFF; md = 32'hA5A5_0001;
        memrq_a = 1'b1;
        step();
        memrq_a = 1'b0;
        check_val("bb_wr_req",   {31'd0, mem_req_a}, 32'd1);
        check_val("bb_wr_we",    {31'd0, mem_we_a}, 32'd1);
        check_val("bb_wr_addr",  {10'd0, mem_addr_a}, 32'h003F_FFFF);
        check_val("bb_wr_wdata", mem_wdata_a, 32'hA5A5_0001);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check_val("bb_wr_done", {31'd0, memstall_a}, 32'd0);
        check_val("bb_ovr",     {31'd0, ovr_a}, 32'd0);
        check_val("bb_mds",     mds_a, 32'h0BAD_F00D);

        // Asynchronous reset in the middle of a read's REQ phase.
        wrcyc = 1'b0; vma = 22'h005555;
        memrq_a = 1'b1;
        step();
        memrq_a = 1'b0;
        check_val("ar_req_pre", {31'd0, mem_req_a}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_val("ar_req_drop", {31'd0, mem_req_a}, 32'd0);
        check_val("ar_stall",    {31'd0, memstall_a}, 32'd0);
        check_val("ar_addr",     {10'd0, mem_addr_a}, 32'd0);
        check_val("ar_mds",      mds_a, 32'd0);
        step();
        reset = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_val("ar_noload", {30'd0, loadmd_a, mem_req_a}, 32'd0);
            step();
        end
        mem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
